// File: rtl/aip_bridge_pkg.sv
// Shared definitions for the picorv32-to-AIP bus bridge: register offsets,
// FSM states and the register decode helper.
package aip_bridge_pkg;

    localparam int AIP_CONF_W = 5;
    localparam int AIP_INT_W  = 16;

    localparam logic [7:0] OFF_DATA  = 8'h00;
    localparam logic [7:0] OFF_CONF  = 8'h04;
    localparam logic [7:0] OFF_START = 8'h08;
    localparam logic [7:0] OFF_PEND  = 8'h0C;
    localparam logic [7:0] OFF_MASK  = 8'h10;

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        WAIT,
        RESP
    } state_e;

    typedef enum logic [2:0] {
        REG_DATA,
        REG_CONF,
        REG_START,
        REG_PEND,
        REG_MASK,
        REG_NONE
    } reg_e;

    function automatic reg_e decode_reg(input logic [7:0] off);
        reg_e r;
        case (off)
            OFF_DATA:  r = REG_DATA;
            OFF_CONF:  r = REG_CONF;
            OFF_START: r = REG_START;
            OFF_PEND:  r = REG_PEND;
            OFF_MASK:  r = REG_MASK;
            default:   r = REG_NONE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aip_irq_latch.sv
// Sticky interrupt latch: core lines OR into PENDING every cycle, CPU clears
// with write-one-to-clear, and a registered IRQ is raised on PENDING & MASK.
module aip_irq_latch
    import aip_bridge_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [AIP_INT_W-1:0] i_int,
    input  logic [AIP_INT_W-1:0] i_clr,
    input  logic                 i_mask_we,
    input  logic [AIP_INT_W-1:0] i_mask_wdata,
    output logic [AIP_INT_W-1:0] o_pending,
    output logic [AIP_INT_W-1:0] o_mask,
    output logic                 o_irq
);

    logic [AIP_INT_W-1:0] pending_q;
    logic [AIP_INT_W-1:0] mask_q;
    logic                 irq_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            mask_q    <= '0;
            irq_q     <= 1'b0;
        end else begin
            // a line that is still high re-sets its bit in the same cycle it is cleared
            pending_q <= (pending_q & ~i_clr) | i_int;
            if (i_mask_we) begin
                mask_q <= i_mask_wdata;
            end
            irq_q <= |(pending_q & mask_q);
        end
    end

    assign o_pending = pending_q;
    assign o_mask    = mask_q;
    assign o_irq     = irq_q;

endmodule

// File: rtl/aip_bus_bridge.sv
// picorv32 native-bus slave that turns register accesses into single-cycle
// AIP read/write/start strobes and reports core interrupts as a masked IRQ.
//
//  state  | meaning
//  IDLE   | waiting for a selected CPU request
//  DECODE | request latched; issue AIP strobe or update bridge register
//  WAIT   | counting read latency before capturing core data
//  RESP   | one-cycle ready pulse with read data
module aip_bus_bridge
    import aip_bridge_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int AW           = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_sel,
    input  logic                  i_cpu_mem_valid,
    input  logic [31:0]           i_cpu_mem_addr,
    input  logic [31:0]           i_cpu_mem_wdata,
    input  logic [3:0]            i_cpu_mem_wstrb,
    output logic [31:0]           o_cpu_mem_rdata,
    output logic                  o_cpu_mem_ready,
    output logic                  o_cpu_irq,
    output logic [31:0]           o_aip_dataIn,
    input  logic [31:0]           i_aip_dataOut,
    output logic [AIP_CONF_W-1:0] o_aip_config,
    output logic                  o_aip_read,
    output logic                  o_aip_write,
    output logic                  o_aip_start,
    input  logic [AIP_INT_W-1:0]  i_aip_int
);

    state_e                state_q, state_d;
    reg_e                  req_reg_q, req_reg_d;
    logic                  req_we_q;
    logic [15:0]           req_wdata_q;
    logic [AIP_CONF_W-1:0] conf_q;
    logic [31:0]           data_in_q;
    logic [31:0]           rdata_q;
    logic [2:0]            wait_q;
    logic                  accept;
    logic                  rd_stb, wr_stb, st_stb, mask_we, ready;
    logic [AIP_INT_W-1:0]  pend_clr, pending, mask;
    logic                  unused_addr;

    assign unused_addr = ^i_cpu_mem_addr[31:AW];
    assign req_reg_d   = decode_reg(8'(i_cpu_mem_addr[AW-1:0]));
    assign accept      = (state_q == IDLE) && i_sel && i_cpu_mem_valid;

    always_comb begin
        state_d  = state_q;
        rd_stb   = 1'b0;
        wr_stb   = 1'b0;
        st_stb   = 1'b0;
        mask_we  = 1'b0;
        pend_clr = '0;
        ready    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = DECODE;
                end
            end
            DECODE: begin
                state_d = RESP;
                if (req_reg_q == REG_DATA) begin
                    if (req_we_q) begin
                        wr_stb = 1'b1;
                    end else begin
                        rd_stb  = 1'b1;
                        state_d = WAIT;
                    end
                end else if (req_we_q) begin
                    case (req_reg_q)
                        REG_START: st_stb   = req_wdata_q[0];
                        REG_PEND:  pend_clr = req_wdata_q[AIP_INT_W-1:0];
                        REG_MASK:  mask_we  = 1'b1;
                        default:   ;
                    endcase
                end
            end
            WAIT: begin
                if (wait_q == 3'd0) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                ready   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_reg_q   <= REG_NONE;
            req_we_q    <= 1'b0;
            req_wdata_q <= '0;
            conf_q      <= '0;
            data_in_q   <= '0;
            rdata_q     <= '0;
            wait_q      <= '0;
        end else begin
            if (accept) begin
                req_reg_q   <= req_reg_d;
                req_we_q    <= |i_cpu_mem_wstrb;
                req_wdata_q <= i_cpu_mem_wdata[15:0];
                // loaded at accept so dataIn is already valid during the write strobe
                if (req_reg_d == REG_DATA && |i_cpu_mem_wstrb) begin
                    data_in_q <= i_cpu_mem_wdata;
                end
            end
            if (state_q == DECODE) begin
                wait_q  <= 3'(READ_LATENCY - 1);
                rdata_q <= '0;
                if (req_we_q) begin
                    if (req_reg_q == REG_CONF) begin
                        conf_q <= req_wdata_q[AIP_CONF_W-1:0];
                    end
                end else begin
                    case (req_reg_q)
                        REG_CONF: rdata_q <= 32'(conf_q);
                        REG_PEND: rdata_q <= 32'(pending);
                        REG_MASK: rdata_q <= 32'(mask);
                        default:  rdata_q <= '0;
                    endcase
                end
            end
            if (state_q == WAIT) begin
                if (wait_q == 3'd0) begin
                    rdata_q <= i_aip_dataOut;
                end else begin
                    wait_q <= wait_q - 3'd1;
                end
            end
        end
    end

    aip_irq_latch u_irq (
        .clk          (clk),
        .rst          (rst),
        .i_int        (i_aip_int),
        .i_clr        (pend_clr),
        .i_mask_we    (mask_we),
        .i_mask_wdata (req_wdata_q[AIP_INT_W-1:0]),
        .o_pending    (pending),
        .o_mask       (mask),
        .o_irq        (o_cpu_irq)
    );

    assign o_cpu_mem_ready = ready;
    assign o_cpu_mem_rdata = ready ? rdata_q : '0;
    assign o_aip_dataIn    = data_in_q;
    assign o_aip_config    = conf_q;
    assign o_aip_read      = rd_stb;
    assign o_aip_write     = wr_stb;
    assign o_aip_start     = st_stb;

endmodule

// File: tb/tb_aip_bus_bridge.sv
// Scoreboard bench for aip_bus_bridge: a register-level model predicts read data,
// latency and AIP strobes; a monitor checks every ready and strobe as it appears.
module tb_aip_bus_bridge;

    localparam int RL = 3;

    typedef struct {
        int          kind;   // 0 read, 1 write, 2 start
        logic [31:0] data;
        logic [4:0]  conf;
    } aip_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_sel, i_cpu_mem_valid;
    logic [31:0] i_cpu_mem_addr, i_cpu_mem_wdata;
    logic [3:0]  i_cpu_mem_wstrb;
    logic [31:0] o_cpu_mem_rdata;
    logic        o_cpu_mem_ready, o_cpu_irq;
    logic [31:0] o_aip_dataIn, i_aip_dataOut;
    logic [4:0]  o_aip_config;
    logic        o_aip_read, o_aip_write, o_aip_start;
    logic [15:0] i_aip_int;

    int n_chk  = 0;
    int n_fail = 0;

    logic [32:0] rsp_q[$];
    aip_t        aip_q[$];

    logic [4:0]  conf_m;
    logic [15:0] mask_m, pend_m;
    logic [31:0] data_in_m;
    logic [31:0] core_val, next_core_val;
    logic [RL-1:0] rd_pipe = '0;
    logic [7:0]  offs [6] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h1C};

    always #5 clk = ~clk;

    aip_bus_bridge #(.READ_LATENCY(RL), .AW(5)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_sel           (i_sel),
        .i_cpu_mem_valid (i_cpu_mem_valid),
        .i_cpu_mem_addr  (i_cpu_mem_addr),
        .i_cpu_mem_wdata (i_cpu_mem_wdata),
        .i_cpu_mem_wstrb (i_cpu_mem_wstrb),
        .o_cpu_mem_rdata (o_cpu_mem_rdata),
        .o_cpu_mem_ready (o_cpu_mem_ready),
        .o_cpu_irq       (o_cpu_irq),
        .o_aip_dataIn    (o_aip_dataIn),
        .i_aip_dataOut   (i_aip_dataOut),
        .o_aip_config    (o_aip_config),
        .o_aip_read      (o_aip_read),
        .o_aip_write     (o_aip_write),
        .o_aip_start     (o_aip_start),
        .i_aip_int       (i_aip_int)
    );

    // Core model: read data is valid only in the cycle exactly RL after the read strobe.
    always @(posedge clk) rd_pipe <= {rd_pipe[RL-2:0], o_aip_read};
    assign i_aip_dataOut = rd_pipe[RL-1] ? core_val : 32'hBAD0_F00D;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboards whenever the DUT presents ready or a strobe.
    initial begin
        logic [32:0] e;
        aip_t        a;
        int          nstb, kind;
        forever begin
            @(negedge clk);
            if (o_cpu_mem_ready) begin
                if (rsp_q.size() == 0) begin
                    check("unexpected_ready", 32'd1, 32'd0);
                end else begin
                    e = rsp_q.pop_front();
                    if (e[32]) check("rdata", o_cpu_mem_rdata, e[31:0]);
                end
            end
            nstb = int'(o_aip_read) + int'(o_aip_write) + int'(o_aip_start);
            if (nstb > 1) begin
                check("strobe_overlap", nstb, 1);
            end else if (nstb == 1) begin
                kind = o_aip_read ? 0 : (o_aip_write ? 1 : 2);
                if (aip_q.size() == 0) begin
                    check("unexpected_strobe", kind + 1, 0);
                end else begin
                    a = aip_q.pop_front();
                    check("strobe_kind", kind, a.kind);
                    check("strobe_config", o_aip_config, a.conf);
                    if (kind == 1) check("strobe_dataIn", o_aip_dataIn, a.data);
                end
            end
        end
    end

    task automatic access(input logic [7:0] off, input logic [31:0] wd,
                          input logic [3:0] ws, input bit drop_early);
        logic [31:0] exp_rd;
        bit          is_rd;
        int          exp_lat, cyc;
        is_rd   = (ws == 4'd0);
        exp_rd  = '0;
        exp_lat = 2;
        case (off)
            8'h00: if (is_rd) begin
                       core_val = next_core_val;
                       exp_rd   = next_core_val;
                       exp_lat  = 2 + RL;
                       aip_q.push_back('{kind: 0, data: 32'h0, conf: conf_m});
                   end else begin
                       data_in_m = wd;
                       aip_q.push_back('{kind: 1, data: wd, conf: conf_m});
                   end
            8'h04: if (is_rd) exp_rd = {27'b0, conf_m}; else conf_m = wd[4:0];
            8'h08: if (!is_rd && wd[0]) aip_q.push_back('{kind: 2, data: 32'h0, conf: conf_m});
            8'h0C: if (is_rd) exp_rd = {16'b0, pend_m}; else pend_m = (pend_m & ~wd[15:0]) | i_aip_int;
            8'h10: if (is_rd) exp_rd = {16'b0, mask_m}; else mask_m = wd[15:0];
            default: ;
        endcase
        rsp_q.push_back({is_rd, exp_rd});
        @(posedge clk); #1;
        i_sel = 1'b1; i_cpu_mem_valid = 1'b1;
        i_cpu_mem_addr = 32'h0300_0000 | {24'b0, off};
        i_cpu_mem_wdata = wd; i_cpu_mem_wstrb = ws;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (o_cpu_mem_ready) break;
            cyc++;
            if (drop_early && cyc == 2) i_cpu_mem_valid = 1'b0;
            if (cyc > 20) begin
                check("ready_timeout", cyc, exp_lat);
                break;
            end
        end
        if (cyc <= 20) check("latency", cyc, exp_lat);
        @(posedge clk); #1;
        i_sel = 1'b0; i_cpu_mem_valid = 1'b0; i_cpu_mem_wstrb = 4'd0;
        check("dataIn_hold", o_aip_dataIn, data_in_m);
        check("config", o_aip_config, conf_m);
    endtask

    task automatic check_irq();
        repeat (2) @(posedge clk);
        #1;
        check("irq", o_cpu_irq, 32'(|(pend_m & mask_m)));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ws;
        logic [15:0] iv;
        rst = 1'b1; i_sel = 1'b0; i_cpu_mem_valid = 1'b0;
        i_cpu_mem_addr = '0; i_cpu_mem_wdata = '0; i_cpu_mem_wstrb = '0;
        i_aip_int = '0; core_val = '0; next_core_val = '0;
        conf_m = '0; mask_m = '0; pend_m = '0; data_in_m = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", {o_cpu_mem_ready, o_cpu_irq, o_aip_read, o_aip_write,
                             o_aip_start, o_aip_config}, 32'h0);
        check("reset_dataIn", o_aip_dataIn, 32'h0);
        rst = 1'b0;

        // put state in the bridge, then reset in the middle of a DATA read
        access(8'h04, 32'h1A, 4'hF, 0);
        access(8'h00, 32'h55AA_1234, 4'hF, 0);
        aip_q.push_back('{kind: 0, data: 32'h0, conf: conf_m});
        @(posedge clk); #1;
        i_sel = 1'b1; i_cpu_mem_valid = 1'b1;
        i_cpu_mem_addr = 32'h0300_0000; i_cpu_mem_wstrb = 4'd0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rst_mid_ctrl", {o_cpu_mem_ready, o_cpu_irq, o_aip_read, o_aip_write,
                               o_aip_start, o_aip_config}, 32'h0);
        check("rst_mid_dataIn", o_aip_dataIn, 32'h0);
        check("rst_mid_rdata", o_cpu_mem_rdata, 32'h0);
        i_sel = 1'b0; i_cpu_mem_valid = 1'b0;
        conf_m = '0; mask_m = '0; pend_m = '0; data_in_m = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // directed cases
        access(8'h04, 32'h05, 4'hF, 0);
        access(8'h00, 32'hDEAD_BEEF, 4'hF, 0);
        next_core_val = 32'h1234_5678;
        access(8'h00, 32'h0, 4'h0, 0);
        access(8'h08, 32'h1, 4'hF, 0);
        access(8'h08, 32'h0, 4'hF, 0);
        access(8'h08, 32'h0, 4'h0, 0);
        access(8'h1C, 32'h0, 4'h0, 0);
        access(8'h1C, 32'hFFFF_FFFF, 4'hF, 0);
        access(8'h04, 32'h0, 4'h0, 1);
        access(8'h04, 32'h13, 4'b0001, 0);
        access(8'h04, 32'h0, 4'h0, 0);

        // interrupt latching, masking and W1C with the line still high
        @(posedge clk); #1 i_aip_int = 16'h0004;
        @(posedge clk); #1 i_aip_int = 16'h0000;
        pend_m |= 16'h0004;
        access(8'h10, 32'h0004, 4'hF, 0);
        check_irq();
        i_aip_int = 16'h0004;
        access(8'h0C, 32'h0004, 4'b0001, 0);
        access(8'h0C, 32'h0, 4'h0, 0);
        i_aip_int = 16'h0000;
        access(8'h0C, 32'h0004, 4'hF, 0);
        access(8'h0C, 32'h0, 4'h0, 0);
        check_irq();

        // randomized traffic
        iv = 16'($urandom);
        @(posedge clk); #1 i_aip_int = iv;
        @(posedge clk); #1 i_aip_int = 16'h0;
        pend_m |= iv;
        for (int i = 0; i < 40; i++) begin
            ws = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
            next_core_val = $urandom;
            access(offs[$urandom_range(0, 5)], $urandom, ws, $urandom_range(0, 3) == 0);
        end
        check_irq();

        repeat (RL + 3) @(posedge clk);
        #1;
        check("rsp_queue_empty", rsp_q.size(), 0);
        check("aip_queue_empty", aip_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
